l1_bus_arbiter: RTL and testbench
=================================

Name: l1_bus_arbiter

Overview:
- Shares the single memory-bus port between the instruction cache (client 0) and the data cache (client 1).
- Both caches drive an identical request/response bus interface. The arbiter grants one client at a time and passes that client's request channel to the bus. It then routes response beats back to the owner.
- One transaction is outstanding at a time. Priority is round-robin.

Parameters:
- BUS_DATA_WIDTH, 64, width of request/response data/address words.
- BUS_TAG_WIDTH, 13, width of request/response tag; MSB = 1 marks a write.
- NUM_BEATS, 8, data beats per cache-line transfer (64 B line / 8 B bus).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- cli_reqcyc  in  2  per-client request valid (bit i = client i)
- cli_req  in  2*BUS_DATA_WIDTH  per-client address/write-data; client i at [i*W +: W]
- cli_reqtag  in  2*BUS_TAG_WIDTH  per-client request tag
- cli_reqack  out  2  per-client request accept
- cli_respcyc  out  2  per-client response valid
- cli_resp  out  BUS_DATA_WIDTH  response data, shared by both clients; valid only where cli_respcyc is set
- cli_resptag  out  BUS_TAG_WIDTH  response tag, shared by both clients
- cli_respack  in  2  per-client response accept
- bus_reqcyc  out  1  bus request valid
- bus_req  out  BUS_DATA_WIDTH  bus address/write data
- bus_reqtag  out  BUS_TAG_WIDTH  bus request tag
- bus_reqack  in  1  bus request accept
- bus_respcyc  in  1  bus response valid
- bus_resp  in  BUS_DATA_WIDTH  bus response data
- bus_resptag  in  BUS_TAG_WIDTH  bus response tag
- bus_respack  out  1  bus response accept

Behaviour:
- Handshakes: a beat transfers on a cycle where the cyc signal and its ack are both high. Clients hold req/reqtag stable until acked.
- Registered state:
  - state: IDLE, ADDR, WDATA or RDATA
  - owner: 1 bit
  - last_grant: 1 bit
  - beat counter: $clog2(NUM_BEATS)+1 bits
- Reset:
  - state=IDLE, counter=0, last_grant=1, so client 0 wins the first tie.
  - All outputs read 0 during and immediately after reset: bus_reqcyc, cli_reqack, cli_respcyc, bus_respack; data/tag outputs are 0 in IDLE.
- Reset mid-transaction abandons the transaction and returns to IDLE. No beat is forwarded on the reset cycle.
- IDLE:
  - No bus or client outputs are asserted.
  - If any cli_reqcyc bit is set, pick the winner: the sole requester, or on a tie the client != last_grant.
  - Register owner=winner and last_grant=winner; next state ADDR. Arbitration latency is 1 cycle.
- ADDR:
  - bus_reqcyc = cli_reqcyc[owner]; bus_req and bus_reqtag come from the owner; cli_reqack[owner] = bus_reqack. All of this is combinational pass-through.
  - On handshake: tag MSB=1 goes to WDATA, otherwise RDATA; counter=0.
  - If the owner drops reqcyc before the handshake, return to IDLE (withdrawal); last_grant keeps the update.
- WDATA:
  - Same pass-through as ADDR. The owner supplies NUM_BEATS write-data beats.
  - Counter increments per handshake. On the handshake where counter==NUM_BEATS-1, go to IDLE.
  - Writes produce no bus response.
- RDATA:
  - cli_respcyc[owner] = bus_respcyc; cli_resp and cli_resptag come from the bus; bus_respack = cli_respack[owner].
  - Counter increments per response handshake. On the handshake where counter==NUM_BEATS-1, go to IDLE.
  - A stalled owner (respack=0) stalls the bus; no beat is dropped.
- Non-owner client:
  - cli_reqack=0 and cli_respcyc=0 at all times.
  - Its request stays pending and is eligible in the next IDLE.
- bus_respcyc outside RDATA: bus_respack=0, nothing is forwarded.
- Request outputs go to 0 in RDATA; response outputs go to 0 outside RDATA.
- Back-to-back transactions: at least one IDLE cycle between transactions, so each transaction takes at least 1 + 1 + NUM_BEATS cycles.
- Fairness: with both clients requesting continuously, grants strictly alternate 0,1,0,1,…

Test Plan:
- Client 0 read, tag 0x0123 (MSB=0), address 0x1000:
  - bus_reqcyc rises 1 cycle after cli_reqcyc, with bus_req=0x1000 and bus_reqtag=0x0123.
  - Ack, then 8 bus beats 0xA0..0xA7 appear on cli_resp with cli_respcyc[0] only; the arbiter returns to IDLE after beat 8.
- Both clients assert reqcyc at the same cycle, each issuing a read:
  - Grant order is client 0, then client 1, then client 0 again if it re-requests.
  - cli_reqack[1] and cli_respcyc[1] stay 0 during client 0's transaction.
- Client 1 write, tag 0x1005 (MSB=1):
  - Address beat plus 8 data beats are forwarded with reqack passed through; no response is expected.
  - A bus_respcyc injected during this transaction sees bus_respack=0.
- Backpressure on a read: hold cli_respack[0]=0 for 3 cycles at beat 4.
  - bus_respack=0 for those cycles; all 8 beats are delivered in order, with no loss or duplication.
- Assert reset during RDATA beat 5:
  - The next cycle state is IDLE and all outputs are 0.
  - A fresh request is then granted normally, with client 0 winning a tie.
- Client 0 drops reqcyc in ADDR before bus_reqack:
  - The arbiter returns to IDLE.
  - A pending client 1 request is granted next.

Source files
------------

// File: rtl/l1_bus_arbiter.sv
// l1_bus_arbiter
//   Shares one memory-bus port between the instruction cache (client 0) and
//   the data cache (client 1). One transaction is outstanding at a time. The
//   winner is chosen round-robin in IDLE. The owner's request channel is then
//   passed straight through to the bus. For reads, the bus response beats are
//   routed back to the owner until NUM_BEATS beats have been accepted.
//
// Ports
//   clk, reset      clock, synchronous active-high reset
//   cli_reqcyc[1:0] per-client request valid
//   cli_req         per-client address/write data, client i at [i*W +: W]
//   cli_reqtag      per-client request tag (MSB = 1 marks a write)
//   cli_reqack[1:0] per-client request accept
//   cli_respcyc     per-client response valid
//   cli_resp        shared response data
//   cli_resptag     shared response tag
//   cli_respack     per-client response accept
//   bus_req*        request channel towards the memory bus
//   bus_resp*       response channel from the memory bus
module l1_bus_arbiter #(
    parameter int BUS_DATA_WIDTH = 64,
    parameter int BUS_TAG_WIDTH  = 13,
    parameter int NUM_BEATS      = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [1:0]                    cli_reqcyc,
    input  logic [2*BUS_DATA_WIDTH-1:0]   cli_req,
    input  logic [2*BUS_TAG_WIDTH-1:0]    cli_reqtag,
    output logic [1:0]                    cli_reqack,
    output logic [1:0]                    cli_respcyc,
    output logic [BUS_DATA_WIDTH-1:0]     cli_resp,
    output logic [BUS_TAG_WIDTH-1:0]      cli_resptag,
    input  logic [1:0]                    cli_respack,
    output logic                          bus_reqcyc,
    output logic [BUS_DATA_WIDTH-1:0]     bus_req,
    output logic [BUS_TAG_WIDTH-1:0]      bus_reqtag,
    input  logic                          bus_reqack,
    input  logic                          bus_respcyc,
    input  logic [BUS_DATA_WIDTH-1:0]     bus_resp,
    input  logic [BUS_TAG_WIDTH-1:0]      bus_resptag,
    output logic                          bus_respack
);

    localparam int CNT_W = $clog2(NUM_BEATS) + 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(NUM_BEATS - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ADDR  = 2'd1,
        ST_WDATA = 2'd2,
        ST_RDATA = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic               owner_q, owner_d;
    logic               last_grant_q, last_grant_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    // Owner's request channel, selected by the registered owner.
    logic                       own_cyc;
    logic [BUS_DATA_WIDTH-1:0]  own_req;
    logic [BUS_TAG_WIDTH-1:0]   own_tag;
    logic                       own_respack;
    logic                       winner;

    always_comb begin
        own_cyc     = owner_q ? cli_reqcyc[1] : cli_reqcyc[0];
        own_req     = owner_q ? cli_req[2*BUS_DATA_WIDTH-1:BUS_DATA_WIDTH]
                              : cli_req[BUS_DATA_WIDTH-1:0];
        own_tag     = owner_q ? cli_reqtag[2*BUS_TAG_WIDTH-1:BUS_TAG_WIDTH]
                              : cli_reqtag[BUS_TAG_WIDTH-1:0];
        own_respack = owner_q ? cli_respack[1] : cli_respack[0];

        // Sole requester wins; on a tie the client that did not win last time.
        winner = (cli_reqcyc == 2'b11) ? ~last_grant_q : cli_reqcyc[1];
    end

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        cnt_d        = cnt_q;

        cli_reqack   = 2'b00;
        cli_respcyc  = 2'b00;
        cli_resp     = '0;
        cli_resptag  = '0;
        bus_reqcyc   = 1'b0;
        bus_req      = '0;
        bus_reqtag   = '0;
        bus_respack  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (|cli_reqcyc) begin
                    owner_d      = winner;
                    last_grant_d = winner;
                    state_d      = ST_ADDR;
                end
            end

            ST_ADDR: begin
                bus_reqcyc          = own_cyc;
                bus_req             = own_req;
                bus_reqtag          = own_tag;
                cli_reqack[owner_q] = bus_reqack;
                if (own_cyc && bus_reqack) begin
                    state_d = own_tag[BUS_TAG_WIDTH-1] ? ST_WDATA : ST_RDATA;
                    cnt_d   = '0;
                end else if (!own_cyc) begin
                    // Owner withdrew before the bus took the address.
                    state_d = ST_IDLE;
                end
            end

            ST_WDATA: begin
                bus_reqcyc          = own_cyc;
                bus_req             = own_req;
                bus_reqtag          = own_tag;
                cli_reqack[owner_q] = bus_reqack;
                if (own_cyc && bus_reqack) begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == LAST_BEAT) begin
                        state_d = ST_IDLE;
                    end
                end
            end

            ST_RDATA: begin
                cli_respcyc[owner_q] = bus_respcyc;
                cli_resp             = bus_resp;
                cli_resptag          = bus_resptag;
                bus_respack          = own_respack;
                if (bus_respcyc && own_respack) begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == LAST_BEAT) begin
                        state_d = ST_IDLE;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Nothing is forwarded on a reset cycle, whatever state we were in.
        if (reset) begin
            cli_reqack  = 2'b00;
            cli_respcyc = 2'b00;
            cli_resp    = '0;
            cli_resptag = '0;
            bus_reqcyc  = 1'b0;
            bus_req     = '0;
            bus_reqtag  = '0;
            bus_respack = 1'b0;
        end
    end

    // last_grant resets to 1 so client 0 wins the first tie.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            owner_q      <= 1'b0;
            last_grant_q <= 1'b1;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
        end
    end

endmodule

// File: tb/tb_l1_bus_arbiter.sv
module tb_l1_bus_arbiter;

    localparam int W  = 64;
    localparam int TW = 13;
    localparam int NB = 8;
    localparam logic [TW-1:0] BT = 13'h0AB5;

    logic           clk = 1'b0;
    logic           reset;
    logic [1:0]     cli_reqcyc;
    logic [W-1:0]   req0, req1;
    logic [TW-1:0]  tag0, tag1;
    logic [2*W-1:0] cli_req;
    logic [2*TW-1:0] cli_reqtag;
    logic [1:0]     cli_reqack;
    logic [1:0]     cli_respcyc;
    logic [W-1:0]   cli_resp;
    logic [TW-1:0]  cli_resptag;
    logic [1:0]     cli_respack;
    logic           bus_reqcyc;
    logic [W-1:0]   bus_req;
    logic [TW-1:0]  bus_reqtag;
    logic           bus_reqack;
    logic           bus_respcyc;
    logic [W-1:0]   bus_resp;
    logic [TW-1:0]  bus_resptag;
    logic           bus_respack;

    assign cli_req    = {req1, req0};
    assign cli_reqtag = {tag1, tag0};

    always #5 clk = ~clk;

    l1_bus_arbiter #(.BUS_DATA_WIDTH(W), .BUS_TAG_WIDTH(TW), .NUM_BEATS(NB)) dut (
        .clk(clk), .reset(reset),
        .cli_reqcyc(cli_reqcyc), .cli_req(cli_req), .cli_reqtag(cli_reqtag),
        .cli_reqack(cli_reqack), .cli_respcyc(cli_respcyc), .cli_resp(cli_resp),
        .cli_resptag(cli_resptag), .cli_respack(cli_respack),
        .bus_reqcyc(bus_reqcyc), .bus_req(bus_req), .bus_reqtag(bus_reqtag),
        .bus_reqack(bus_reqack), .bus_respcyc(bus_respcyc), .bus_resp(bus_resp),
        .bus_resptag(bus_resptag), .bus_respack(bus_respack)
    );

    typedef struct {
        logic [1:0]    cyc;
        logic [1:0]    respack;
        logic          breqack;
        logic          brespcyc;
        logic [W-1:0]  bresp;
        logic          e_bus_reqcyc;
        logic [W-1:0]  e_bus_req;
        logic [TW-1:0] e_bus_reqtag;
        logic [1:0]    e_cli_reqack;
        logic [1:0]    e_cli_respcyc;
        logic          e_bus_respack;
        logic [W-1:0]  e_cli_resp;
        logic [TW-1:0] e_cli_resptag;
    } vec_t;

    vec_t tbl[$];
    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Advance to just after the next rising edge, where inputs are changed.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_quiet(input string name);
        chk({name, ".bus_reqcyc"},  W'(bus_reqcyc),  '0);
        chk({name, ".cli_reqack"},  W'(cli_reqack),  '0);
        chk({name, ".cli_respcyc"}, W'(cli_respcyc), '0);
        chk({name, ".bus_respack"}, W'(bus_respack), '0);
        chk({name, ".cli_resp"},    cli_resp,        '0);
        chk({name, ".bus_req"},     bus_req,         '0);
    endtask

    task automatic row_idle(input logic [1:0] cyc, input logic brc);
        vec_t v;
        v = '{cyc, 2'b01, 1'b0, brc, 64'hEE, 1'b0, '0, '0, 2'b00, 2'b00, 1'b0, '0, '0};
        tbl.push_back(v);
    endtask

    task automatic row_addr0(input logic ack);
        vec_t v;
        v = '{2'b01, 2'b01, ack, 1'b0, '0, 1'b1, 64'h1000, 13'h0123,
              (ack ? 2'b01 : 2'b00), 2'b00, 1'b0, '0, '0};
        tbl.push_back(v);
    endtask

    task automatic row_beat(input logic [W-1:0] d, input logic ack);
        vec_t v;
        v = '{2'b00, (ack ? 2'b01 : 2'b00), 1'b0, 1'b1, d, 1'b0, '0, '0,
              2'b00, 2'b01, ack, d, BT};
        tbl.push_back(v);
    endtask

    initial begin
        // Plain client-0 read: IDLE, ADDR stall, ADDR ack, 8 beats, IDLE with stray response.
        row_idle(2'b01, 1'b0);
        row_addr0(1'b0);
        row_addr0(1'b1);
        for (int k = 0; k < NB; k++) row_beat(64'hA0 + 64'(k), 1'b1);
        row_idle(2'b00, 1'b1);
        // Second read with client backpressure for 3 cycles at beat 4.
        row_idle(2'b01, 1'b0);
        row_addr0(1'b1);
        for (int k = 0; k < 3; k++) row_beat(64'hA0 + 64'(k), 1'b1);
        for (int k = 0; k < 3; k++) row_beat(64'hA3, 1'b0);
        for (int k = 3; k < NB; k++) row_beat(64'hA0 + 64'(k), 1'b1);
        row_idle(2'b00, 1'b1);

        reset = 1'b1; cli_reqcyc = 2'b00; cli_respack = 2'b00;
        req0 = 64'h1000; tag0 = 13'h0123; req1 = 64'h2000; tag1 = 13'h0456;
        bus_reqack = 1'b0; bus_respcyc = 1'b0; bus_resp = '0; bus_resptag = BT;
        repeat (2) next_cycle();
        cli_reqcyc = 2'b01;
        @(negedge clk);
        chk_quiet("reset_hold");
        next_cycle();
        reset = 1'b0;

        foreach (tbl[i]) begin
            cli_reqcyc  = tbl[i].cyc;
            cli_respack = tbl[i].respack;
            bus_reqack  = tbl[i].breqack;
            bus_respcyc = tbl[i].brespcyc;
            bus_resp    = tbl[i].bresp;
            @(negedge clk);
            chk($sformatf("row%0d.bus_reqcyc", i),  W'(bus_reqcyc),  W'(tbl[i].e_bus_reqcyc));
            chk($sformatf("row%0d.bus_req", i),     bus_req,         tbl[i].e_bus_req);
            chk($sformatf("row%0d.bus_reqtag", i),  W'(bus_reqtag),  W'(tbl[i].e_bus_reqtag));
            chk($sformatf("row%0d.cli_reqack", i),  W'(cli_reqack),  W'(tbl[i].e_cli_reqack));
            chk($sformatf("row%0d.cli_respcyc", i), W'(cli_respcyc), W'(tbl[i].e_cli_respcyc));
            chk($sformatf("row%0d.bus_respack", i), W'(bus_respack), W'(tbl[i].e_bus_respack));
            chk($sformatf("row%0d.cli_resp", i),    cli_resp,        tbl[i].e_cli_resp);
            chk($sformatf("row%0d.cli_resptag", i), W'(cli_resptag), W'(tbl[i].e_cli_resptag));
            next_cycle();
        end
        bus_respcyc = 1'b0;

        // Client 1 read, reset asserted on beat 5.
        cli_reqcyc = 2'b10; cli_respack = 2'b10;
        @(negedge clk); chk_quiet("rst_seq.idle");
        next_cycle();
        bus_reqack = 1'b1;
        @(negedge clk);
        chk("rst_seq.addr_req", bus_req, 64'h2000);
        chk("rst_seq.addr_ack", W'(cli_reqack), W'(2'b10));
        next_cycle();
        bus_reqack = 1'b0; cli_reqcyc = 2'b00;
        for (int k = 0; k < 4; k++) begin
            bus_respcyc = 1'b1; bus_resp = 64'hB0 + 64'(k);
            @(negedge clk);
            chk($sformatf("rst_seq.beat%0d_cyc", k), W'(cli_respcyc), W'(2'b10));
            chk($sformatf("rst_seq.beat%0d_data", k), cli_resp, 64'hB0 + 64'(k));
            next_cycle();
        end
        reset = 1'b1; bus_resp = 64'hB4;
        @(negedge clk); chk_quiet("rst_seq.reset_cycle");
        next_cycle();
        reset = 1'b0;
        @(negedge clk); chk_quiet("rst_seq.after_reset");
        next_cycle();
        bus_respcyc = 1'b0;

        // Tie: client 0 wins first, then client 1, then client 0 again.
        cli_reqcyc = 2'b11; cli_respack = 2'b11;
        @(negedge clk); chk_quiet("tie.idle");
        next_cycle();
        @(negedge clk);
        chk("tie.addr_req0", bus_req, 64'h1000);
        chk("tie.addr_noack", W'(cli_reqack), W'(2'b00));
        next_cycle();
        bus_reqack = 1'b1;
        @(negedge clk); chk("tie.addr_ack0", W'(cli_reqack), W'(2'b01));
        next_cycle();
        bus_reqack = 1'b0; cli_reqcyc = 2'b10;
        for (int k = 0; k < NB; k++) begin
            bus_respcyc = 1'b1; bus_resp = 64'hC0 + 64'(k);
            @(negedge clk);
            chk($sformatf("tie.c0_beat%0d_cyc", k), W'(cli_respcyc), W'(2'b01));
            chk($sformatf("tie.c0_beat%0d_reqack", k), W'(cli_reqack), W'(2'b00));
            chk($sformatf("tie.c0_beat%0d_data", k), cli_resp, 64'hC0 + 64'(k));
            next_cycle();
        end
        bus_respcyc = 1'b0;
        @(negedge clk); chk_quiet("tie.gap");
        next_cycle();
        bus_reqack = 1'b1;
        @(negedge clk);
        chk("tie.addr_req1", bus_req, 64'h2000);
        chk("tie.addr_ack1", W'(cli_reqack), W'(2'b10));
        next_cycle();
        // Client 1 now queues a write while client 0 re-requests.
        bus_reqack = 1'b0; cli_reqcyc = 2'b11; req1 = 64'h3000; tag1 = 13'h1005;
        cli_respack = 2'b10;
        for (int k = 0; k < NB; k++) begin
            bus_respcyc = 1'b1; bus_resp = 64'hE0 + 64'(k);
            @(negedge clk);
            chk($sformatf("tie.c1_beat%0d_cyc", k), W'(cli_respcyc), W'(2'b10));
            chk($sformatf("tie.c1_beat%0d_breq", k), W'(bus_reqcyc), '0);
            next_cycle();
        end
        bus_respcyc = 1'b0;
        @(negedge clk); chk_quiet("tie.gap2");
        next_cycle();

        // Third grant goes to client 0, which withdraws before the address ack.
        cli_reqcyc = 2'b10;
        @(negedge clk);
        chk("wd.addr_req0", bus_req, 64'h1000);
        chk("wd.bus_reqcyc", W'(bus_reqcyc), '0);
        chk("wd.reqack", W'(cli_reqack), '0);
        next_cycle();
        @(negedge clk); chk_quiet("wd.idle");
        next_cycle();

        // Client 1 write: address, then 8 data beats with one stall and a stray response.
        bus_reqack = 1'b1;
        @(negedge clk);
        chk("wr.addr", bus_req, 64'h3000);
        chk("wr.tag", W'(bus_reqtag), W'(13'h1005));
        chk("wr.addr_ack", W'(cli_reqack), W'(2'b10));
        next_cycle();
        for (int k = 0; k < NB; k++) begin
            req1 = 64'hD0 + 64'(k);
            if (k == 3) begin
                bus_reqack = 1'b0; bus_respcyc = 1'b1;
                @(negedge clk);
                chk("wr.stall_ack", W'(cli_reqack), W'(2'b00));
                chk("wr.stall_cyc", W'(bus_reqcyc), W'(1'b1));
                chk("wr.stray_respack", W'(bus_respack), '0);
                chk("wr.stray_respcyc", W'(cli_respcyc), '0);
                next_cycle();
                bus_reqack = 1'b1; bus_respcyc = 1'b0;
            end
            @(negedge clk);
            chk($sformatf("wr.beat%0d_data", k), bus_req, 64'hD0 + 64'(k));
            chk($sformatf("wr.beat%0d_ack", k), W'(cli_reqack), W'(2'b10));
            next_cycle();
        end
        bus_reqack = 1'b0; cli_reqcyc = 2'b00;
        @(negedge clk); chk_quiet("wr.done");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
